esfa_benchmark_controller: RTL and testbench

Command sequencer that sits between the UART host-link process interface and the ESFA benchmark engine. Decodes host commands and launches N back-to-back benchmark runs via single-cycle doRun pulses. Supervises each run with timeouts, accumulates cycle and success counts, and returns a status byte plus 32-bit result through the existing dataReceived/clearDR/transmitData handshake.

---
 rtl/esfa_ctrl_pkg.sv | 27 ++
 rtl/esfa_benchmark_controller_if.sv | 24 ++
 rtl/esfa_sat_counter.sv | 20 ++
 rtl/esfa_benchmark_controller.sv | 132 +++++++++++++
 tb/tb_esfa_benchmark_controller.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/esfa_ctrl_pkg.sv
// rtl/esfa_ctrl_pkg.sv - shared opcodes, status bit positions and FSM encoding
package esfa_ctrl_pkg;

   localparam logic [3:0] CMD_NOP   = 4'h0;
   localparam logic [3:0] CMD_RUN   = 4'h1;
   localparam logic [3:0] CMD_QUERY = 4'h2;

   localparam int ST_DONE     = 7;
   localparam int ST_START_TO = 6;
   localparam int ST_RUN_TO   = 5;
   localparam int ST_BADCMD   = 4;

   localparam logic [7:0] STATUS_BADCMD = 8'h10;

   typedef enum logic [3:0] {
      S_IDLE,
      S_DECODE,
      S_LAUNCH,
      S_WAIT_START,
      S_WAIT_DONE,
      S_NEXT,
      S_FINISH,
      S_REPORT,
      S_HANDSHAKE
   } state_t;

endpackage

// File: rtl/esfa_benchmark_controller_if.sv
// rtl/esfa_benchmark_controller_if.sv - host-link and engine signals of the benchmark controller
interface esfa_benchmark_controller_if;
   logic        dataReceived;
   logic [7:0]  control;
   logic [31:0] inputData;
   logic        clearDR;
   logic        transmitData;
   logic [7:0]  status;
   logic [31:0] outputData;
   logic        doRun;
   logic        isRunning;
   logic        wasSuccessful;
   logic        busy;

   modport slave (
      input  dataReceived, control, inputData, isRunning, wasSuccessful,
      output clearDR, transmitData, status, outputData, doRun, busy
   );

   modport master (
      output dataReceived, control, inputData, isRunning, wasSuccessful,
      input  clearDR, transmitData, status, outputData, doRun, busy
   );
endinterface

// File: rtl/esfa_sat_counter.sv
// rtl/esfa_sat_counter.sv - saturating up-counter with synchronous clear and enable
module esfa_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/esfa_benchmark_controller.sv
// rtl/esfa_benchmark_controller.sv - decodes host commands, launches and supervises N engine runs
module esfa_benchmark_controller
   import esfa_ctrl_pkg::*;
#(
   parameter int unsigned START_TIMEOUT = 16,
   parameter logic [31:0] RUN_TIMEOUT   = 32'd100_000_000,
   parameter int unsigned CMD_WIDTH     = 4
) (
   input  logic                        masterClock,
   input  logic                        reset,
   esfa_benchmark_controller_if.slave  bus
);

   state_t                 state, state_next;
   logic [CMD_WIDTH-1:0]   cmd_q;
   logic [31:0]            n_q;
   logic [31:0]            iter;
   logic                   start_to, run_to;
   logic [7:0]             status_q;
   logic [31:0]            result_q;
   logic [31:0]            cycles, timer;
   logic [3:0]             succ;

   logic is_run, is_keep, start_expired, run_expired, run_end;
   logic cyc_clr, cyc_en, timer_clr, succ_en;

   wire unused_ctrl = &{1'b0, bus.control[7:CMD_WIDTH]};

   assign is_run        = (cmd_q == CMD_WIDTH'(CMD_RUN));
   assign is_keep       = (cmd_q == CMD_WIDTH'(CMD_NOP)) || (cmd_q == CMD_WIDTH'(CMD_QUERY));
   assign start_expired = (timer == 32'(START_TIMEOUT - 1));
   assign run_expired   = (timer == RUN_TIMEOUT - 32'd1);
   assign run_end       = (state == S_WAIT_DONE) && !bus.isRunning;

   // Cycle count spans every launch/wait state plus the NEXT gaps that lead to another launch.
   assign cyc_clr   = (state == S_DECODE) && is_run;
   assign cyc_en    = (state == S_LAUNCH) || (state == S_WAIT_START) || (state == S_WAIT_DONE) ||
                      ((state == S_NEXT) && (iter != 32'd0));
   assign timer_clr = !((state == S_WAIT_START) || (state == S_WAIT_DONE)) ||
                      ((state == S_WAIT_START) && bus.isRunning);
   assign succ_en   = run_end && bus.wasSuccessful;

   esfa_sat_counter #(.WIDTH(32)) u_cycles (
      .clk(masterClock), .reset(reset), .clr(cyc_clr), .en(cyc_en), .count(cycles)
   );
   esfa_sat_counter #(.WIDTH(32)) u_timer (
      .clk(masterClock), .reset(reset), .clr(timer_clr), .en(!timer_clr), .count(timer)
   );
   esfa_sat_counter #(.WIDTH(4)) u_succ (
      .clk(masterClock), .reset(reset), .clr(cyc_clr), .en(succ_en), .count(succ)
   );

   always_ff @(posedge masterClock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Run completion wins over a timeout that expires in the same cycle.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:       if (bus.dataReceived) state_next = S_DECODE;
         S_DECODE:     state_next = is_run ? S_LAUNCH : S_REPORT;
         S_LAUNCH:     state_next = S_WAIT_START;
         S_WAIT_START: if (bus.isRunning)   state_next = S_WAIT_DONE;
                       else if (start_expired) state_next = S_FINISH;
         S_WAIT_DONE:  if (!bus.isRunning)  state_next = S_NEXT;
                       else if (run_expired) state_next = S_FINISH;
         S_NEXT:       state_next = (iter == 32'd0) ? S_FINISH : S_LAUNCH;
         S_FINISH:     state_next = S_REPORT;
         S_REPORT:     state_next = S_HANDSHAKE;
         S_HANDSHAKE:  if (!bus.dataReceived) state_next = S_IDLE;
         default:      state_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.doRun        = 1'b0;
      bus.transmitData = 1'b0;
      bus.clearDR      = 1'b0;
      bus.busy         = (state != S_IDLE);
      case (state)
         S_LAUNCH:               bus.doRun = 1'b1;
         S_REPORT, S_HANDSHAKE: begin
            bus.transmitData = 1'b1;
            bus.clearDR      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge masterClock) begin
      if (reset) begin
         cmd_q    <= '0;
         n_q      <= '0;
         iter     <= '0;
         start_to <= 1'b0;
         run_to   <= 1'b0;
         status_q <= '0;
         result_q <= '0;
      end else begin
         case (state)
            S_IDLE: if (bus.dataReceived) begin
               cmd_q <= bus.control[CMD_WIDTH-1:0];
               n_q   <= bus.inputData;
            end
            S_DECODE: if (is_run) begin
               iter     <= (n_q == 32'd0) ? 32'd1 : n_q;
               start_to <= 1'b0;
               run_to   <= 1'b0;
            end else if (!is_keep) begin
               status_q <= STATUS_BADCMD;
               result_q <= '0;
            end
            S_WAIT_START: if (!bus.isRunning && start_expired) start_to <= 1'b1;
            S_WAIT_DONE: begin
               if (!bus.isRunning)  iter   <= iter - 32'd1;
               else if (run_expired) run_to <= 1'b1;
            end
            S_FINISH: begin
               status_q <= {1'b1, start_to, run_to, 1'b0, succ};
               result_q <= cycles;
            end
            default: ;
         endcase
      end
   end

   assign bus.status     = status_q;
   assign bus.outputData = result_q;

endmodule

// File: tb/tb_esfa_benchmark_controller.sv
// tb/tb_esfa_benchmark_controller.sv - randomized bench with engine model and run-level reference
module tb_esfa_benchmark_controller;

   localparam int START_TO = 16;
   localparam int RUN_TO   = 50;

   logic masterClock = 1'b0;
   logic reset;
   always #5 masterClock = ~masterClock;

   esfa_benchmark_controller_if bus ();

   esfa_benchmark_controller #(
      .START_TIMEOUT(START_TO),
      .RUN_TIMEOUT(32'(RUN_TO)),
      .CMD_WIDTH(4)
   ) dut (
      .masterClock(masterClock),
      .reset(reset),
      .bus(bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Per-launch engine behaviour for the current command: start delay, busy length, result.
   int d_arr [32];
   int b_arr [32];
   bit s_arr [32];
   int launches = 0;
   int consec   = 0;
   int cmd_base = 0;
   bit eng_kill = 1'b0;

   initial begin
      int  phase, wait_c, rem, idx;
      bit  cur_s, prev_dorun;
      phase = 0; wait_c = 0; rem = 0; cur_s = 0; prev_dorun = 0;
      bus.isRunning     = 1'b0;
      bus.wasSuccessful = 1'b0;
      forever begin
         @(posedge masterClock);
         #1;
         if (eng_kill) begin
            phase = 0;
            bus.isRunning     = 1'b0;
            bus.wasSuccessful = 1'b0;
         end else if (phase == 1) begin
            if (wait_c == 0) begin
               bus.isRunning     = 1'b1;
               bus.wasSuccessful = 1'($urandom_range(0, 1));
               phase = 2;
            end else begin
               wait_c--;
            end
         end else if (phase == 2) begin
            if (rem == 0) begin
               bus.isRunning     = 1'b0;
               bus.wasSuccessful = cur_s;
               phase = 0;
            end else begin
               rem--;
               bus.wasSuccessful = 1'($urandom_range(0, 1));
            end
         end
         if (bus.doRun) begin
            if (prev_dorun) consec++;
            idx = (launches - cmd_base) % 32;
            launches++;
            phase  = 1;
            wait_c = d_arr[idx];
            rem    = b_arr[idx] - 1;
            cur_s  = s_arr[idx];
         end
         prev_dorun = bus.doRun;
      end
   end

   // Reference: each completed run costs launch + (delay+1) start cycles + busy length,
   // runs are separated by one gap cycle, and a timeout ends the command.
   task automatic model_run(input int n, output logic [7:0] st, output logic [31:0] od, output int nl);
      int     runs;
      longint cyc;
      int     sc;
      logic [7:0] fl;
      runs = (n == 0) ? 1 : n;
      cyc = 0; sc = 0; fl = 8'h00; nl = 0;
      for (int i = 0; i < runs; i++) begin
         nl++;
         if (i > 0) cyc++;
         if (d_arr[i] >= START_TO) begin cyc += 1 + START_TO; fl = 8'h40; break; end
         cyc += 2 + d_arr[i];
         if (b_arr[i] > RUN_TO) begin cyc += RUN_TO; fl = 8'h20; break; end
         cyc += b_arr[i];
         if (s_arr[i] && sc < 15) sc++;
      end
      st = 8'h80 | fl | 8'(sc);
      od = (cyc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(cyc);
   endtask

   task automatic eng_reset();
      @(negedge masterClock);
      eng_kill = 1'b1;
      @(negedge masterClock);
      @(negedge masterClock);
      eng_kill = 1'b0;
      cmd_base = launches;
   endtask

   task automatic send_cmd(input string tag, input logic [7:0] ctrl, input logic [31:0] data,
                           output logic [7:0] st, output logic [31:0] od);
      int cnt;
      @(negedge masterClock);
      bus.control      = ctrl;
      bus.inputData    = data;
      bus.dataReceived = 1'b1;
      cnt = 0;
      while (!bus.transmitData && cnt < 5000) begin
         @(negedge masterClock);
         cnt++;
      end
      check_eq({tag, "_tx"}, 64'(bus.transmitData), 64'd1);
      check_eq({tag, "_clr"}, 64'(bus.clearDR), 64'd1);
      st = bus.status;
      od = bus.outputData;
      repeat ($urandom_range(0, 3)) @(negedge masterClock);
      check_eq({tag, "_hold"}, 64'(bus.transmitData & bus.clearDR), 64'd1);
      bus.dataReceived = 1'b0;
      @(negedge masterClock);
      check_eq({tag, "_pair"}, 64'(bus.transmitData), 64'(bus.clearDR));
      @(negedge masterClock);
      check_eq({tag, "_drop"}, 64'({bus.transmitData, bus.clearDR, bus.busy}), 64'd0);
      check_eq({tag, "_stable"}, 64'({bus.status, bus.outputData}), 64'({st, od}));
   endtask

   logic [7:0]  last_st = 8'h00;
   logic [31:0] last_od = 32'h0;

   task automatic do_run(input string tag, input logic [7:0] ctrl, input int n);
      logic [7:0]  est, st;
      logic [31:0] eod, od;
      int          enl, base, cbase;
      eng_reset();
      model_run(n, est, eod, enl);
      base  = launches;
      cbase = consec;
      send_cmd(tag, ctrl, 32'(n), st, od);
      check_eq({tag, "_status"}, 64'(st), 64'(est));
      check_eq({tag, "_cycles"}, 64'(od), 64'(eod));
      check_eq({tag, "_launches"}, 64'(launches - base), 64'(enl));
      check_eq({tag, "_backtoback"}, 64'(consec - cbase), 64'd0);
      last_st = est;
      last_od = eod;
   endtask

   task automatic do_other(input string tag, input logic [7:0] ctrl, input bit bad);
      logic [7:0]  st;
      logic [31:0] od;
      int          base;
      eng_reset();
      if (bad) begin last_st = 8'h10; last_od = 32'h0; end
      base = launches;
      send_cmd(tag, ctrl, $urandom, st, od);
      check_eq({tag, "_status"}, 64'(st), 64'(last_st));
      check_eq({tag, "_data"}, 64'(od), 64'(last_od));
      check_eq({tag, "_launches"}, 64'(launches - base), 64'd0);
   endtask

   task automatic fill(input int d, input int b, input bit s);
      for (int i = 0; i < 32; i++) begin
         d_arr[i] = d; b_arr[i] = b; s_arr[i] = s;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, r, n;
      reset            = 1'b1;
      bus.dataReceived = 1'b0;
      bus.control      = 8'h00;
      bus.inputData    = 32'h0;
      fill(0, 1, 1);
      repeat (3) @(negedge masterClock);
      check_eq("reset_outs", 64'({bus.doRun, bus.clearDR, bus.transmitData, bus.busy}), 64'd0);
      check_eq("reset_status", 64'(bus.status), 64'd0);
      check_eq("reset_data", 64'(bus.outputData), 64'd0);
      reset = 1'b0;

      fill(0, 10, 1);   do_run("run3", 8'h01, 3);
      fill(0, 3, 1);    do_run("run0", 8'h01, 0);
      fill(1000, 5, 1); do_run("nostart", 8'h01, 2);
      fill(0, 1000, 1); do_run("stuck", 8'h01, 1);
      do_other("badcmd", 8'h07, 1'b1);
      do_other("query", 8'h02, 1'b0);
      do_other("nop", 8'hA0, 1'b0);
      fill(15, 50, 1);  do_run("edge_ok", 8'h01, 1);
      fill(16, 50, 1);  do_run("edge_start", 8'h01, 1);
      fill(0, 51, 1);   do_run("edge_run", 8'h01, 1);
      fill(0, 1, 1);    do_run("sat15", 8'hF1, 17);

      for (int k = 0; k < 25; k++) begin
         for (int i = 0; i < 32; i++) begin
            d_arr[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 20) : $urandom_range(0, 15);
            b_arr[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(51, 60) : $urandom_range(1, 50);
            s_arr[i] = 1'($urandom_range(0, 1));
         end
         r = $urandom_range(0, 9);
         n = $urandom_range(0, 4);
         if (r < 7)       do_run("rnd_run", {4'($urandom_range(0, 15)), 4'h1}, n);
         else if (r == 7) do_other("rnd_nop", {4'($urandom_range(0, 15)), 4'h0}, 1'b0);
         else if (r == 8) do_other("rnd_query", {4'($urandom_range(0, 15)), 4'h2}, 1'b0);
         else             do_other("rnd_bad", {4'($urandom_range(0, 15)), 4'($urandom_range(3, 15))}, 1'b1);
      end

      // Reset while the engine is mid-run: no report, everything back to zero.
      eng_reset();
      fill(0, 30, 1);
      @(negedge masterClock);
      bus.control      = 8'h01;
      bus.inputData    = 32'd1;
      bus.dataReceived = 1'b1;
      cnt = 0;
      while (!bus.isRunning && cnt < 100) begin
         @(negedge masterClock);
         cnt++;
      end
      check_eq("midrun_started", 64'(bus.isRunning), 64'd1);
      repeat (5) @(negedge masterClock);
      reset            = 1'b1;
      bus.dataReceived = 1'b0;
      @(negedge masterClock);
      check_eq("midrun_outs", 64'({bus.doRun, bus.clearDR, bus.transmitData, bus.busy}), 64'd0);
      check_eq("midrun_status", 64'({bus.status, bus.outputData}), 64'd0);
      reset = 1'b0;
      eng_reset();
      repeat (10) @(negedge masterClock);
      check_eq("midrun_quiet", 64'({bus.transmitData, bus.busy}), 64'd0);
      last_st = 8'h00;
      last_od = 32'h0;
      do_other("after_reset_query", 8'h02, 1'b0);
      fill(2, 7, 1);    do_run("after_reset_run", 8'h01, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
